txn_score_scheduler: RTL and testbench
======================================

// Module: txn_score_scheduler
// PURPOSE
// Round-robin scheduler that shares one transaction-scoring engine between NUM_REQ wallet streams.
// Per batch it grants one requester, issues the engine's new_wallet clear with the batch start time,
// streams that requester's transactions into the engine, waits for the score to settle, then returns
// the confidence score, beat count and status. Sits between the wallet ingest queues and the scoring datapath.
// PARAMETERS
// NUM_REQ      4      number of requesters (2..8); index width IW = clog2(NUM_REQ)
// MAX_TXN      1024   beats per batch before forced truncation (<= 65535)
// SETTLE_CYC   3      cycles between last engine beat and eng_score capture (>= 1)
// IDLE_TMO     255    cycles with no tx_valid from grantee (CLEAR/STREAM) before abort (>= 1)
// PORTS
// clk            in   1          clock; all logic on posedge
// rst            in   1          synchronous reset, active-high
// req_valid      in   NUM_REQ    requester i has a batch pending
// req_grant      out  NUM_REQ    one-hot grant, held from ARB exit until result accepted
// tx_valid       in   NUM_REQ    per-requester beat valid
// tx_last        in   NUM_REQ    final beat of batch
// tx_in          in   NUM_REQ    inbound(1)/outbound(0) flag
// tx_method      in   2*NUM_REQ  method field (00 tether, 01 monero, 10 other)
// tx_value       in   20*NUM_REQ transaction value
// tx_time        in   31*NUM_REQ time stamp
// tx_ready       out  NUM_REQ    beat accepted when tx_valid[i]&tx_ready[i]
// eng_new_wallet out  1          one-cycle engine clear
// eng_txn_valid  out  1          engine accumulates only in cycles where this is 1
// eng_in/eng_method/eng_value/eng_time  out  1/2/20/31  registered beat to engine
// eng_score      in   7          engine confidence score
// result_valid   out  1          result held until result_ready
// result_ready   in   1          consumer accept
// result_id      out  IW         requester index of the batch
// result_score   out  7          captured score; 0 on abort
// result_count   out  16         beats accepted
// result_err     out  2          00 ok, 01 truncated at MAX_TXN, 10 timeout abort
// busy           out  1          state != IDLE
// BEHAVIOUR
// - Reset: all outputs 0, FSM=IDLE, RR pointer=NUM_REQ-1 (requester 0 wins first). Reset mid-batch abandons
//   it: no result emitted, engine not cleared by rst (next batch's CLEAR does that).
// - FSM IDLE -> ARB when |req_valid. ARB (1 cycle): grant first set req_valid searching from ptr+1 modulo
//   NUM_REQ; ptr <= grantee; req_grant asserted from next cycle. -> CLEAR.
// - CLEAR: wait for tx_valid[g]; in that cycle drive eng_new_wallet=1, eng_time=tx_time[g] (beat NOT
//   consumed, tx_ready=0); count, timer reset. -> STREAM.
// - STREAM: tx_ready[g]=1 (others 0). Accepted beat registered onto eng_* with eng_txn_valid=1 next cycle;
//   eng_txn_valid=0 in every other cycle. count saturates at 65535 (unreachable given MAX_TXN).
//   Exit on accepted tx_last (err 00), or accepted beat making count==MAX_TXN without last (err 01;
//   remaining beats left to requester). Simultaneous last and count==MAX_TXN: err 00. -> SETTLE.
// - Timeout: timer counts cycles with tx_valid[g]=0 in CLEAR/STREAM, clears on tx_valid[g]=1; reaching
//   IDLE_TMO -> RESULT with err 10, score 0, count as accepted.
// - SETTLE: SETTLE_CYC cycles after the final eng_txn_valid beat; last cycle captures eng_score. -> RESULT.
// - RESULT: result_valid=1, fields stable; on result_ready: result_valid<=0, req_grant<=0, -> IDLE.
//   Next ARB no earlier than cycle after IDLE; req_valid drop mid-batch ignored.
// - Fixed beat-to-score latency: last beat accept at T -> eng beat T+1 -> result_valid at T+1+SETTLE_CYC+1.
// TESTING
// 1 Reset: rst high 2 cycles mid-STREAM -> all outputs 0, busy 0; req_valid=0001 -> grant 0001 in 2 cycles.
// 2 RR fairness: req_valid=1111 held, 1-beat batches, result_ready=1 -> grant order 0001,0010,0100,1000,0001.
// 3 Batch of 5 beats from req 2 (tx_time first=1000), eng_score=42 -> one new_wallet with eng_time=1000,
//   five eng_txn_valid pulses, result id=2 score=42 count=5 err=00 at last accept+SETTLE_CYC+2.
// 4 MAX_TXN=8, 12 beats no last -> tx_ready drops after 8th, count=8 err=01; last on beat 8 -> err=00.
// 5 Grantee withholds tx_valid 255 cycles after 3 beats -> result err=10 score=0 count=3; no extra engine beats.
// 6 result_ready low 20 cycles -> result fields/grant stable, other req_valid not granted until accept.

Source files
------------

// File: rtl/txn_score_scheduler.sv
// Round-robin share of one transaction-scoring engine across NUM_REQ wallet streams.
// Latency: last beat accepted at T -> engine beat T+1 -> result_valid at T+SETTLE_CYC+2.
// Backpressure: only the grantee sees tx_ready (STREAM only); result held until result_ready.
module txn_score_scheduler #(
  parameter  int NUM_REQ    = 4,
  parameter  int MAX_TXN    = 1024,
  parameter  int SETTLE_CYC = 3,
  parameter  int IDLE_TMO   = 255,
  localparam int IW         = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_grant,
  input  logic [NUM_REQ-1:0]      tx_valid,
  input  logic [NUM_REQ-1:0]      tx_last,
  input  logic [NUM_REQ-1:0]      tx_in,
  input  logic [2*NUM_REQ-1:0]    tx_method,
  input  logic [20*NUM_REQ-1:0]   tx_value,
  input  logic [31*NUM_REQ-1:0]   tx_time,
  output logic [NUM_REQ-1:0]      tx_ready,
  output logic                    eng_new_wallet,
  output logic                    eng_txn_valid,
  output logic                    eng_in,
  output logic [1:0]              eng_method,
  output logic [19:0]             eng_value,
  output logic [30:0]             eng_time,
  input  logic [6:0]              eng_score,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [IW-1:0]           result_id,
  output logic [6:0]              result_score,
  output logic [15:0]             result_count,
  output logic [1:0]              result_err,
  output logic                    busy
);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_CLEAR, S_STREAM, S_SETTLE, S_RESULT} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d, gidx_q, gidx_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [15:0]          count_q, count_d, timer_q, timer_d;
  logic [7:0]           settle_q, settle_d;
  logic [1:0]           err_q, err_d;
  logic                 nw_q, nw_d, tv_q, tv_d, ein_q, ein_d;
  logic [1:0]           emeth_q, emeth_d;
  logic [19:0]          evalue_q, evalue_d;
  logic [30:0]          etime_q, etime_d;
  logic                 rv_q, rv_d;
  logic [IW-1:0]        rid_q, rid_d;
  logic [6:0]           rscore_q, rscore_d;
  logic [15:0]          rcount_q, rcount_d;
  logic [1:0]           rerr_q, rerr_d;

  logic                 arb_found;
  logic [IW-1:0]        arb_idx;
  logic                 g_valid, g_last, g_in;
  logic [1:0]           g_method;
  logic [19:0]          g_value;
  logic [30:0]          g_time;
  logic [15:0]          count_inc;

  // Grantee beat fields, selected by the registered grant index
  always_comb begin
    g_valid   = tx_valid[gidx_q];
    g_last    = tx_last[gidx_q];
    g_in      = tx_in[gidx_q];
    g_method  = tx_method[int'(gidx_q)*2 +: 2];
    g_value   = tx_value[int'(gidx_q)*20 +: 20];
    g_time    = tx_time[int'(gidx_q)*31 +: 31];
    count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
  end

  // Round-robin search: first pending requester after the last grantee
  always_comb begin
    int cand;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr_q) + k) % NUM_REQ;
      if (!arb_found && req_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = IW'(cand);
      end
    end
  end

  // Next-state and registered-output computation for the batch FSM
  always_comb begin
    state_d  = state_q;   ptr_d    = ptr_q;    gidx_d   = gidx_q;
    grant_d  = grant_q;   count_d  = count_q;  timer_d  = timer_q;
    settle_d = settle_q;  err_d    = err_q;
    nw_d     = 1'b0;      tv_d     = 1'b0;     ein_d    = ein_q;
    emeth_d  = emeth_q;   evalue_d = evalue_q; etime_d  = etime_q;
    rv_d     = rv_q;      rid_d    = rid_q;    rscore_d = rscore_q;
    rcount_d = rcount_q;  rerr_d   = rerr_q;

    case (state_q)
      S_IDLE: if (|req_valid) state_d = S_ARB;
      S_ARB: begin
        if (arb_found) begin
          gidx_d           = arb_idx;
          ptr_d            = arb_idx;
          grant_d          = '0;
          grant_d[arb_idx] = 1'b1;
          count_d          = '0;
          timer_d          = '0;
          state_d          = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR, S_STREAM: begin
        if (g_valid) begin
          timer_d = '0;
          if (state_q == S_CLEAR) begin
            // Clear the engine with the batch start time; this beat is not consumed
            nw_d    = 1'b1;
            etime_d = g_time;
            count_d = '0;
            state_d = S_STREAM;
          end else begin
            tv_d     = 1'b1;
            ein_d    = g_in;
            emeth_d  = g_method;
            evalue_d = g_value;
            etime_d  = g_time;
            count_d  = count_inc;
            settle_d = '0;
            if (g_last) begin
              err_d   = 2'b00;
              state_d = S_SETTLE;
            end else if (count_inc == 16'(MAX_TXN)) begin
              err_d   = 2'b01;
              state_d = S_SETTLE;
            end
          end
        end else if (timer_q == 16'(IDLE_TMO - 1)) begin
          rv_d     = 1'b1;
          rid_d    = gidx_q;
          rscore_d = '0;
          rcount_d = count_q;
          rerr_d   = 2'b10;
          state_d  = S_RESULT;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_SETTLE: begin
        // First SETTLE cycle carries the final engine beat; capture SETTLE_CYC cycles later
        if (settle_q == 8'(SETTLE_CYC)) begin
          rv_d     = 1'b1;
          rid_d    = gidx_q;
          rscore_d = eng_score;
          rcount_d = count_q;
          rerr_d   = err_q;
          state_d  = S_RESULT;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      S_RESULT: begin
        if (result_ready) begin
          rv_d    = 1'b0;
          grant_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any batch in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;        ptr_q    <= IW'(NUM_REQ - 1); gidx_q <= '0;
      grant_q  <= '0;            count_q  <= '0;  timer_q  <= '0;
      settle_q <= '0;            err_q    <= '0;  nw_q     <= 1'b0;
      tv_q     <= 1'b0;          ein_q    <= 1'b0; emeth_q <= '0;
      evalue_q <= '0;            etime_q  <= '0;  rv_q     <= 1'b0;
      rid_q    <= '0;            rscore_q <= '0;  rcount_q <= '0;
      rerr_q   <= '0;
    end else begin
      state_q  <= state_d;       ptr_q    <= ptr_d;    gidx_q   <= gidx_d;
      grant_q  <= grant_d;       count_q  <= count_d;  timer_q  <= timer_d;
      settle_q <= settle_d;      err_q    <= err_d;    nw_q     <= nw_d;
      tv_q     <= tv_d;          ein_q    <= ein_d;    emeth_q  <= emeth_d;
      evalue_q <= evalue_d;      etime_q  <= etime_d;  rv_q     <= rv_d;
      rid_q    <= rid_d;         rscore_q <= rscore_d; rcount_q <= rcount_d;
      rerr_q   <= rerr_d;
    end
  end

  assign req_grant      = grant_q;
  assign tx_ready       = (state_q == S_STREAM) ? grant_q : '0;
  assign eng_new_wallet = nw_q;
  assign eng_txn_valid  = tv_q;
  assign eng_in         = ein_q;
  assign eng_method     = emeth_q;
  assign eng_value      = evalue_q;
  assign eng_time       = etime_q;
  assign result_valid   = rv_q;
  assign result_id      = rid_q;
  assign result_score   = rscore_q;
  assign result_count   = rcount_q;
  assign result_err     = rerr_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_txn_score_scheduler.sv
// Bench for txn_score_scheduler: directed batches with a result scoreboard and engine-beat watcher.
// Latency: results checked on handshake; engine beats and result timing checked per batch.
// Backpressure: result_ready held low in one scenario to check result/grant stability.
module tb_txn_score_scheduler;
  localparam int NR = 4, MAXT = 8, SC = 3, TMO = 255;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_grant, tx_valid, tx_last, tx_in, tx_ready;
  logic [2*NR-1:0]   tx_method;
  logic [20*NR-1:0]  tx_value;
  logic [31*NR-1:0]  tx_time;
  logic              eng_new_wallet, eng_txn_valid, eng_in;
  logic [1:0]        eng_method;
  logic [19:0]       eng_value;
  logic [30:0]       eng_time;
  logic [6:0]        eng_score;
  logic              result_valid, result_ready, busy;
  logic [1:0]        result_id, result_err;
  logic [6:0]        result_score;
  logic [15:0]       result_count;

  always #5 clk = ~clk;

  txn_score_scheduler #(.NUM_REQ(NR), .MAX_TXN(MAXT), .SETTLE_CYC(SC), .IDLE_TMO(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_grant(req_grant),
    .tx_valid(tx_valid), .tx_last(tx_last), .tx_in(tx_in), .tx_method(tx_method),
    .tx_value(tx_value), .tx_time(tx_time), .tx_ready(tx_ready),
    .eng_new_wallet(eng_new_wallet), .eng_txn_valid(eng_txn_valid), .eng_in(eng_in),
    .eng_method(eng_method), .eng_value(eng_value), .eng_time(eng_time),
    .eng_score(eng_score), .result_valid(result_valid), .result_ready(result_ready),
    .result_id(result_id), .result_score(result_score), .result_count(result_count),
    .result_err(result_err), .busy(busy));

  typedef struct packed {
    logic [1:0]  id;
    logic [6:0]  sc;
    logic [15:0] cnt;
    logic [1:0]  err;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0;
  int   rv_events = 0, rv_cyc = 0, nw_cnt = 0, ev_cnt = 0;
  logic rv_prev = 1'b0;
  logic [30:0] nw_time = '0;
  logic [19:0] last_ev_value = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop and compare each accepted result
  always @(negedge clk) begin
    if (!rst && result_valid && result_ready) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got id %0d, none expected", result_id);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("res_id", result_id, e.id);
        check("res_score", result_score, e.sc);
        check("res_count", result_count, e.cnt);
        check("res_err", result_err, e.err);
      end
    end
  end

  // Watcher: engine clears/beats and result_valid rising edges
  always @(negedge clk) begin
    if (result_valid && !rv_prev) begin
      rv_events++;
      rv_cyc = cyc;
    end
    rv_prev = result_valid;
    if (eng_new_wallet) begin
      nw_cnt++;
      nw_time = eng_time;
    end
    if (eng_txn_valid) begin
      ev_cnt++;
      last_ev_value = eng_value;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int idx, input int t0, input int j, input bit last);
    tx_valid[idx]            = 1'b1;
    tx_last[idx]             = last;
    tx_in[idx]               = j[0];
    tx_method[idx*2 +: 2]    = 2'(j % 3);
    tx_value[idx*20 +: 20]   = 20'(j * 7 + 1);
    tx_time[idx*31 +: 31]    = 31'(t0 + j);
  endtask

  task automatic wait_grant(input logic [NR-1:0] exp, input string nm);
    int g = 0;
    while (req_grant == '0 && g < 20) begin
      tick();
      g++;
    end
    check(nm, req_grant, exp);
  endtask

  // Offer beats until n accepted or a result appears; returns accepted count and last accept cycle
  task automatic drive_beats(input int idx, input int n, input bit use_last, input int t0,
                             output int acc, output int t_last);
    int guard = 0;
    acc = 0;
    t_last = 0;
    while (acc < n && guard < 100 && !result_valid) begin
      set_beat(idx, t0, acc, use_last && (acc == n - 1));
      if (tx_ready[idx]) begin
        acc++;
        t_last = cyc;
      end
      tick();
      guard++;
    end
    tx_valid = '0;
    tx_last  = '0;
  endtask

  task automatic wait_result(input int ev0, input string nm);
    int g = 0;
    while (rv_events == ev0 && g < 400) begin
      tick();
      g++;
    end
    check(nm, rv_events - ev0, 1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, tl, ev0, nw0, e0;
    rst = 1'b1; req_valid = '0; tx_valid = '0; tx_last = '0; tx_in = '0;
    tx_method = '0; tx_value = '0; tx_time = '0; eng_score = '0; result_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // 1: reset mid-stream, then first grant to requester 0 two cycles later
    req_valid = 4'b0001;
    wait_grant(4'b0001, "t1_grant_pre");
    for (int j = 0; j < 3; j++) begin
      set_beat(0, 50, j, 1'b0);
      tick();
    end
    rst = 1'b1; tx_valid = '0; req_valid = '0;
    tick();
    tick();
    check("t1_rst_ctrl", {req_grant, tx_ready, eng_new_wallet, eng_txn_valid, result_valid,
                          busy, result_err, result_id}, 64'd0);
    check("t1_rst_eng", {eng_in, eng_method, eng_value, eng_time}, 64'd0);
    check("t1_rst_res", {result_score, result_count}, 64'd0);
    rst = 1'b0;
    req_valid = 4'b0001;
    tick();
    check("t1_grant_c1", req_grant, 4'b0000);
    tick();
    check("t1_grant_c2", req_grant, 4'b0001);
    req_valid = '0;
    eng_score = 7'd5;
    sbq.push_back('{id: 2'd0, sc: 7'd5, cnt: 16'd1, err: 2'b00});
    ev0 = rv_events;
    drive_beats(0, 1, 1'b1, 60, acc, tl);
    wait_result(ev0, "t1_result");

    // 2: round-robin order with all requesters pending
    pulse_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant(4'(1 << (i % 4)), "t2_rr_grant");
      eng_score = 7'(10 + i);
      sbq.push_back('{id: 2'(i % 4), sc: 7'(10 + i), cnt: 16'd1, err: 2'b00});
      ev0 = rv_events;
      drive_beats(i % 4, 1, 1'b1, 100 * i, acc, tl);
      wait_result(ev0, "t2_result");
    end
    req_valid = '0;
    tick();

    // 3: five-beat batch from requester 2
    req_valid = 4'b0100;
    wait_grant(4'b0100, "t3_grant");
    req_valid = '0;
    nw0 = nw_cnt; e0 = ev_cnt; ev0 = rv_events;
    eng_score = 7'd42;
    sbq.push_back('{id: 2'd2, sc: 7'd42, cnt: 16'd5, err: 2'b00});
    drive_beats(2, 5, 1'b1, 1000, acc, tl);
    wait_result(ev0, "t3_result");
    check("t3_accepted", acc, 5);
    check("t3_new_wallet", nw_cnt - nw0, 1);
    check("t3_eng_time", nw_time, 1000);
    check("t3_eng_beats", ev_cnt - e0, 5);
    check("t3_last_value", last_ev_value, 29);
    check("t3_latency", rv_cyc - tl, SC + 2);

    // 4a: truncation at MAX_TXN without last
    req_valid = 4'b1000;
    wait_grant(4'b1000, "t4a_grant");
    req_valid = '0;
    e0 = ev_cnt; ev0 = rv_events;
    eng_score = 7'd17;
    sbq.push_back('{id: 2'd3, sc: 7'd17, cnt: 16'd8, err: 2'b01});
    drive_beats(3, 12, 1'b0, 2000, acc, tl);
    wait_result(ev0, "t4a_result");
    check("t4a_accepted", acc, 8);
    check("t4a_eng_beats", ev_cnt - e0, 8);
    // 4b: last coinciding with MAX_TXN reports ok
    req_valid = 4'b0001;
    wait_grant(4'b0001, "t4b_grant");
    req_valid = '0;
    ev0 = rv_events;
    sbq.push_back('{id: 2'd0, sc: 7'd17, cnt: 16'd8, err: 2'b00});
    drive_beats(0, 8, 1'b1, 3000, acc, tl);
    wait_result(ev0, "t4b_result");
    check("t4b_accepted", acc, 8);

    // 5: idle timeout after three beats
    req_valid = 4'b0010;
    wait_grant(4'b0010, "t5_grant");
    req_valid = '0;
    e0 = ev_cnt; ev0 = rv_events;
    eng_score = 7'd55;
    sbq.push_back('{id: 2'd1, sc: 7'd0, cnt: 16'd3, err: 2'b10});
    drive_beats(1, 3, 1'b0, 4000, acc, tl);
    wait_result(ev0, "t5_result");
    check("t5_eng_beats", ev_cnt - e0, 3);
    check("t5_timeout_cycles", rv_cyc - tl, TMO + 1);

    // 6: result held under backpressure; other requester waits
    req_valid = 4'b0010;
    wait_grant(4'b0010, "t6_grant");
    req_valid = 4'b0100;
    result_ready = 1'b0;
    eng_score = 7'd99;
    ev0 = rv_events;
    sbq.push_back('{id: 2'd1, sc: 7'd99, cnt: 16'd2, err: 2'b00});
    drive_beats(1, 2, 1'b1, 500, acc, tl);
    wait_result(ev0, "t6_result");
    for (int k = 0; k < 20; k++) begin
      tick();
      check("t6_hold_fields", {result_valid, result_id, result_score, result_count, result_err},
            {1'b1, 2'd1, 7'd99, 16'd2, 2'b00});
      check("t6_hold_grant", req_grant, 4'b0010);
    end
    result_ready = 1'b1;
    tick();
    wait_grant(4'b0100, "t6_next_grant");
    req_valid = '0;
    ev0 = rv_events;
    sbq.push_back('{id: 2'd2, sc: 7'd99, cnt: 16'd1, err: 2'b00});
    drive_beats(2, 1, 1'b1, 600, acc, tl);
    wait_result(ev0, "t6_next_result");

    repeat (3) tick();
    check("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
